// File: rtl/framebuffer_swap_controller.sv
// Double-buffered framebuffer sequencer: clears the back buffer, hands the
// write port to the renderer, then swaps front/back on the frame-boundary
// pulse once rendering is done. Late frames are counted in missed_frames.
module framebuffer_swap_controller #(
    parameter int                     WIDTH       = 320,
    parameter int                     HEIGHT      = 240,
    parameter int                     COLOR_WIDTH = 12,
    parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = 12'h000,
    localparam int                    PIXELS      = WIDTH * HEIGHT,
    localparam int                    ADDR_WIDTH  = $clog2(PIXELS)
) (
    input  logic                   clk_rgb,
    input  logic                   rst,
    input  logic                   swap,
    output logic                   render_start,
    input  logic                   render_done,
    input  logic                   rnd_we,
    input  logic [ADDR_WIDTH-1:0]  rnd_addr,
    input  logic [COLOR_WIDTH-1:0] rnd_data,
    output logic                   fb_we,
    output logic [ADDR_WIDTH-1:0]  fb_addr,
    output logic [COLOR_WIDTH-1:0] fb_data,
    output logic                   fb_sel,
    output logic                   front_sel,
    output logic [7:0]             missed_frames
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(PIXELS - 1);

    typedef enum logic [1:0] {
        ST_CLEAR     = 2'd0,
        ST_RENDER    = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } state_t;

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_cnt;
    logic                   r_front_sel;
    logic                   r_render_start;
    logic [7:0]             r_missed;
    logic                   r_fb_we;
    logic [ADDR_WIDTH-1:0]  r_fb_addr;
    logic [COLOR_WIDTH-1:0] r_fb_data;
    logic                   r_fb_sel;

    state_t                 w_state_nxt;
    logic [ADDR_WIDTH-1:0]  w_cnt_nxt;
    logic                   w_front_nxt;
    logic                   w_start_nxt;
    logic                   w_miss;
    logic [7:0]             w_missed_nxt;
    logic                   w_req_we;
    logic [ADDR_WIDTH-1:0]  w_req_addr;
    logic [COLOR_WIDTH-1:0] w_req_data;

    // Next-state, write-request selection and missed-swap detection.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_front_nxt = r_front_sel;
        w_start_nxt = 1'b0;
        w_miss      = 1'b0;
        w_req_we    = 1'b0;
        w_req_addr  = r_cnt;
        w_req_data  = CLEAR_COLOR;
        case (r_state)
            ST_CLEAR: begin
                // Clear writes own the port; renderer writes are dropped.
                w_req_we   = 1'b1;
                w_req_addr = r_cnt;
                w_req_data = CLEAR_COLOR;
                w_miss     = swap;
                if (r_cnt == ADDR_LAST) begin
                    w_cnt_nxt   = ADDR_ZERO;
                    w_state_nxt = ST_RENDER;
                    w_start_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_ONE;
                end
            end
            ST_RENDER: begin
                // A write in the render_done cycle is still forwarded.
                w_req_we   = rnd_we;
                w_req_addr = rnd_addr;
                w_req_data = rnd_data;
                w_miss     = swap;
                if (render_done) begin
                    w_state_nxt = ST_WAIT_SWAP;
                end else begin
                    w_state_nxt = ST_RENDER;
                end
            end
            ST_WAIT_SWAP: begin
                if (swap) begin
                    w_front_nxt = ~r_front_sel;
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = ADDR_ZERO;
                end else begin
                    w_state_nxt = ST_WAIT_SWAP;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = ADDR_ZERO;
            end
        endcase

        if (w_miss && (r_missed != 8'hFF)) begin
            w_missed_nxt = r_missed + 8'd1;
        end else begin
            w_missed_nxt = r_missed;
        end
    end

    // Control state: FSM, clear counter, buffer index, start pulse, miss count.
    always_ff @(posedge clk_rgb or posedge rst) begin
        if (rst) begin
            r_state        <= ST_CLEAR;
            r_cnt          <= ADDR_ZERO;
            r_front_sel    <= 1'b0;
            r_render_start <= 1'b0;
            r_missed       <= 8'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_front_sel    <= w_front_nxt;
            r_render_start <= w_start_nxt;
            r_missed       <= w_missed_nxt;
        end
    end

    // Back-buffer write port, tagged with the back index of the request cycle.
    always_ff @(posedge clk_rgb or posedge rst) begin
        if (rst) begin
            r_fb_we   <= 1'b0;
            r_fb_addr <= ADDR_ZERO;
            r_fb_data <= {COLOR_WIDTH{1'b0}};
            r_fb_sel  <= 1'b1;
        end else begin
            r_fb_we   <= w_req_we;
            r_fb_addr <= w_req_addr;
            r_fb_data <= w_req_data;
            r_fb_sel  <= ~r_front_sel;
        end
    end

    assign render_start  = r_render_start;
    assign fb_we         = r_fb_we;
    assign fb_addr       = r_fb_addr;
    assign fb_data       = r_fb_data;
    assign fb_sel        = r_fb_sel;
    assign front_sel     = r_front_sel;
    assign missed_frames = r_missed;

endmodule

// File: doc/framebuffer_swap_controller.md
Name: framebuffer_swap_controller

Overview:
- Sequences the double-buffered framebuffer behind the display scan-out.
- Owns the back-buffer write port. Each frame it clears the back buffer to a background colour, then hands the write port to the renderer.
- When the renderer reports completion, it waits for the frame-boundary swap pulse from the pixel timing generator, then exchanges the front and back buffers.
- Counts frames where the swap pulse arrived before rendering finished.

Parameters:
- WIDTH, 320, active pixels per line.
- HEIGHT, 240, active lines per frame.
- COLOR_WIDTH, 12, bits per pixel.
- CLEAR_COLOR, 12'h000, value written to every back-buffer pixel during clear.
- Derived localparam PIXELS = WIDTH*HEIGHT.
- Derived localparam ADDR_WIDTH = $clog2(PIXELS).

Ports:
- clk_rgb  in  1  pixel clock; sole clock.
- rst  in  1  asynchronous, active-high reset.
- swap  in  1  one-cycle frame-boundary pulse from the pixel timing generator.
- render_start  out  1  one-cycle pulse: back buffer cleared, renderer may draw.
- render_done  in  1  renderer finished the current frame; level or pulse.
- rnd_we  in  1  renderer write enable.
- rnd_addr  in  ADDR_WIDTH  renderer pixel address (y*WIDTH+x).
- rnd_data  in  COLOR_WIDTH  renderer pixel value.
- fb_we  out  1  back-buffer write enable, registered.
- fb_addr  out  ADDR_WIDTH  back-buffer write address, registered.
- fb_data  out  COLOR_WIDTH  back-buffer write data, registered.
- fb_sel  out  1  buffer index targeted by the fb_* write, registered with it.
- front_sel  out  1  buffer index the display reads.
- missed_frames  out  8  saturating count of swap pulses not honoured.

Behaviour:
- Reset is asynchronous, active-high. On assertion:
  - state=CLEAR, clear counter=0, front_sel=0.
  - render_start=0, fb_we=0, fb_addr=0, fb_data=0, fb_sel=1, missed_frames=0.
- Back buffer index is always ~front_sel.
- The fb_* outputs are registered. Each cycle's write request appears on fb_* the following cycle, tagged with fb_sel = ~front_sel as sampled in the request cycle.
- State CLEAR:
  - Each cycle, request a write of CLEAR_COLOR at the counter address; counter increments.
  - At counter==PIXELS-1, that write is issued, counter returns to 0 and state goes to RENDER.
  - Exactly PIXELS writes are issued, covering addresses 0..PIXELS-1 in order.
- render_start is registered. It is high for exactly the first cycle spent in RENDER.
- State RENDER:
  - Write request = rnd_we/rnd_addr/rnd_data.
  - render_done is sampled every RENDER cycle, including the render_start cycle.
  - If render_done=1, go to WAIT_SWAP. A write presented in that same cycle is still forwarded.
- State WAIT_SWAP:
  - No write requests; rnd_we is ignored.
  - On swap=1: front_sel toggles, state goes to CLEAR, counter=0.
  - The first clear write after a swap targets the new back buffer, i.e. the old front.
- rnd_we is ignored in CLEAR and WAIT_SWAP; renderer writes are never merged with clear writes.
- render_done is ignored outside RENDER.
- A swap pulse arriving in CLEAR or RENDER:
  - missed_frames increments, saturating at 255.
  - front_sel is unchanged and the state is unaffected.
- swap and render_done high in the same RENDER cycle: go to WAIT_SWAP and count a miss. That swap is not honoured; the next swap pulse is.
- Toggling front_sel from a swap pulse has zero added latency: front_sel changes on the clock edge that samples swap=1.
- Reset asserted mid-clear or mid-render:
  - Abandon immediately and return to reset values.
  - No render_start pulse is produced until a full clear completes.
- Address arithmetic is unsigned in ADDR_WIDTH bits. The counter never exceeds PIXELS-1.

Test Plan:
- WIDTH=4, HEIGHT=2; release reset, hold render_done=0:
  - fb_we=1 for 8 consecutive cycles, fb_addr 0..7, fb_data=CLEAR_COLOR, fb_sel=1.
  - render_start pulses once, on the cycle after the last clear request.
- In RENDER, drive rnd_we=1, addr=5, data=12'hABC:
  - Next cycle fb_we=1, fb_addr=5, fb_data=12'hABC, fb_sel=1.
  - rnd_we during CLEAR produces no fb write.
- Assert render_done for 1 cycle, wait 10 cycles, pulse swap:
  - front_sel goes 0->1 on that edge.
  - New clear sweep 0..7 with fb_sel=0; missed_frames stays 0.
- Pulse swap 3 times during CLEAR/RENDER: missed_frames=3 and front_sel unchanged. Force 300 misses: missed_frames holds at 255.
- render_done and swap in the same RENDER cycle:
  - State becomes WAIT_SWAP and missed_frames increments.
  - front_sel toggles only on the next swap pulse.
- Assert rst asynchronously mid-clear (counter=4), between clock edges:
  - Outputs go to reset values immediately, without waiting for an edge.
  - After release, a full sweep restarts at address 0 with fb_sel=1.
